// File: rtl/dtw_result_filter.sv
// dtw_result_filter
//   Scans the DTW accelerator's per-query result stream ({ref pos, cost} per
//   beat, query delimited by tlast). It keeps the best and second-best cost of
//   each query and emits a two-beat summary per query:
//     word0 = {best_pos, best_cost}
//     word1 = {match, hit_cnt[14:0], second_cost}
//   match = (best <= cost_thresh) && ((second - best) >= cost_margin)
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   clr                synchronous soft clear (drops the partial query)
//   cost_thresh        max best cost for a match (sampled on the tlast beat)
//   cost_margin        min (second - best) for a match (sampled on tlast beat)
//   s_axis_*           result beat input stream
//   m_axis_*           summary output stream (tlast marks word1)
//   query_cnt          summaries fully emitted since reset/clr (wraps)
//   busy               a query is partly accumulated or a summary is in flight
module dtw_result_filter #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int CNT_MAX            = 32767
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              clr,
    input  logic [15:0]                       cost_thresh,
    input  logic [15:0]                       cost_margin,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [(C_AXIS_TDATA_WIDTH/8)-1:0] m_axis_tstrb,
    output logic                              m_axis_tlast,
    output logic [31:0]                       query_cnt,
    output logic                              busy
);

    localparam logic [14:0] CNT_SAT = 15'(CNT_MAX);

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_EMIT0 = 2'd1,
        S_EMIT1 = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [15:0] best_cost, second_cost, best_pos;
    logic [14:0] hit_cnt;
    logic        match_q;

    logic [15:0] in_pos, in_cost;
    logic [15:0] nxt_best, nxt_second, nxt_pos;
    logic [14:0] nxt_hit;
    logic        nxt_match;
    logic        beat_acc;

    assign in_pos        = s_axis_tdata[31:16];
    assign in_cost       = s_axis_tdata[15:0];
    assign s_axis_tready = (state == S_ACC);
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign m_axis_tstrb  = '1;
    assign busy          = (state != S_ACC) || (hit_cnt != '0);

    // Accumulator update including the beat currently on the input, so the
    // tlast beat's own cost takes part in the registered summary.
    always_comb begin
        nxt_best   = best_cost;
        nxt_second = second_cost;
        nxt_pos    = best_pos;
        nxt_hit    = hit_cnt;
        if (in_cost < best_cost) begin
            nxt_second = best_cost;
            nxt_best   = in_cost;
            nxt_pos    = in_pos;
        end else if (in_cost < second_cost) begin
            nxt_second = in_cost;
        end
        if (hit_cnt < CNT_SAT) begin
            nxt_hit = hit_cnt + 15'd1;
        end
        // second >= best always holds, so the subtraction cannot wrap
        nxt_match = (nxt_best <= cost_thresh) &&
                    ((nxt_second - nxt_best) >= cost_margin);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC:   if (beat_acc && s_axis_tlast) state_nxt = S_EMIT0;
            S_EMIT0: if (m_axis_tready)            state_nxt = S_EMIT1;
            S_EMIT1: if (m_axis_tready)            state_nxt = S_ACC;
            default:                               state_nxt = S_ACC;
        endcase
        if (clr) begin
            state_nxt = S_ACC;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            best_cost     <= '1;
            second_cost   <= '1;
            best_pos      <= '0;
            hit_cnt       <= '0;
            match_q       <= 1'b0;
            query_cnt     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (clr) begin
            best_cost     <= '1;
            second_cost   <= '1;
            best_pos      <= '0;
            hit_cnt       <= '0;
            match_q       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            if (!busy) begin
                query_cnt <= '0;
            end
        end else begin
            case (state)
                S_ACC: begin
                    if (beat_acc) begin
                        best_cost   <= nxt_best;
                        second_cost <= nxt_second;
                        best_pos    <= nxt_pos;
                        hit_cnt     <= nxt_hit;
                        if (s_axis_tlast) begin
                            match_q       <= nxt_match;
                            m_axis_tdata  <= {nxt_pos, nxt_best};
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b0;
                        end
                    end
                end
                S_EMIT0: begin
                    // accumulators are still frozen here, so word1 is built
                    // from them plus the match bit captured on the tlast beat
                    if (m_axis_tready) begin
                        m_axis_tdata <= {match_q, hit_cnt, second_cost};
                        m_axis_tlast <= 1'b1;
                    end
                end
                S_EMIT1: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        query_cnt     <= query_cnt + 32'd1;
                        best_cost     <= '1;
                        second_cost   <= '1;
                        best_pos      <= '0;
                        hit_cnt       <= '0;
                        match_q       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_result_filter.sv
module tb_dtw_result_filter;

    localparam int TB_CNT = 20;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        clr;
    logic [15:0] cost_thresh, cost_margin;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic [31:0] query_cnt;
    logic        busy;

    logic        mon_en = 1'b1;
    logic        mon_ready = 1'b0;
    logic        man_ready = 1'b0;
    assign m_tready = mon_en ? mon_ready : man_ready;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] sb[$];
    int          mon_qcnt = 0;
    int          qcnt_off = 0;

    always #5 aclk = ~aclk;

    dtw_result_filter #(.C_AXIS_TDATA_WIDTH(32), .CNT_MAX(TB_CNT)) dut (
        .aclk(aclk), .aresetn(aresetn), .clr(clr),
        .cost_thresh(cost_thresh), .cost_margin(cost_margin),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb),
        .m_axis_tlast(m_tlast), .query_cnt(query_cnt), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: best/second are the two smallest of the costs together with
    // the two FFFF initial values; best_pos is the first position holding the
    // best cost, or 0 when nothing beat FFFF.
    function automatic void model(input logic [31:0] beats[$], input logic [15:0] th,
                                  input logic [15:0] mg, output logic [31:0] w0,
                                  output logic [31:0] w1);
        int c[$];
        logic [15:0] best, second, pos;
        int n;
        c.push_back(65535);
        c.push_back(65535);
        foreach (beats[i]) c.push_back(int'(beats[i][15:0]));
        c.sort();
        best   = 16'(c[0]);
        second = 16'(c[1]);
        pos    = 16'h0;
        if (best != 16'hFFFF) begin
            for (int i = beats.size() - 1; i >= 0; i--)
                if (beats[i][15:0] == best) pos = beats[i][31:16];
        end
        n  = (beats.size() > TB_CNT) ? TB_CNT : beats.size();
        w0 = {pos, best};
        w1 = {(best <= th) && ((second - best) >= mg), 15'(n), second};
    endfunction

    task automatic send_beat(input logic [31:0] d, input bit last);
        int t;
        repeat ($urandom_range(0, 1)) @(negedge aclk);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        t = 0;
        while (!s_tready && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_accept_timeout: got no tready expected tready");
        end else begin
            @(posedge aclk);
            @(negedge aclk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_query(input logic [31:0] beats[$], input bit rnd_cfg);
        logic [31:0] w0, w1;
        for (int i = 0; i < beats.size(); i++) begin
            if (rnd_cfg && $urandom_range(0, 2) == 0) begin
                cost_thresh = 16'($urandom);
                cost_margin = 16'($urandom_range(0, 400));
            end
            if (i == beats.size() - 1) begin
                model(beats, cost_thresh, cost_margin, w0, w1);
                sb.push_back({1'b0, w0});
                sb.push_back({1'b1, w1});
            end
            send_beat(beats[i], i == beats.size() - 1);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || m_tvalid) && t < 5000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 5000) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // Monitor: chooses m_tready, checks holding while stalled and pops the
    // scoreboard on every output handshake.
    initial begin
        logic        have_prev;
        logic [31:0] prev_d;
        logic        prev_l;
        logic        pend_q;
        logic [32:0] exp;
        int          n_word0, stall;
        have_prev = 1'b0; pend_q = 1'b0; n_word0 = 0; stall = 0;
        prev_d = '0; prev_l = 1'b0;
        forever begin
            @(negedge aclk);
            if (mon_en && aresetn) begin
                if (pend_q) begin
                    check("query_cnt", query_cnt, 32'(mon_qcnt - qcnt_off));
                    pend_q = 1'b0;
                end
                if (m_tvalid) begin
                    check("s_tready_stalled", {31'b0, s_tready}, 32'd0);
                    if (have_prev) begin
                        check("hold_tdata", m_tdata, prev_d);
                        check("hold_tlast", {31'b0, m_tlast}, {31'b0, prev_l});
                    end else if (!m_tlast) begin
                        n_word0++;
                        if (n_word0 == 3) stall = 5;
                    end
                    if (stall > 0) begin
                        mon_ready = 1'b0;
                        stall--;
                    end else begin
                        mon_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (mon_ready) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_beat: got %h expected none", m_tdata);
                        end else begin
                            exp = sb.pop_front();
                            check("tdata", m_tdata, exp[31:0]);
                            check("tlast", {31'b0, m_tlast}, {31'b0, exp[32]});
                        end
                        have_prev = 1'b0;
                        if (m_tlast) begin
                            mon_qcnt++;
                            pend_q = 1'b1;
                        end
                    end else begin
                        have_prev = 1'b1;
                        prev_d    = m_tdata;
                        prev_l    = m_tlast;
                    end
                end else begin
                    have_prev = 1'b0;
                    mon_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        logic [31:0] q[$];
        int t;
        aresetn = 1'b0; clr = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        cost_thresh = 16'd0; cost_margin = 16'd0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_s_tready", {31'b0, s_tready}, 32'd1);
        check("rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tlast", {31'b0, m_tlast}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_query_cnt", query_cnt, 32'd0);
        check("tstrb", {28'b0, m_tstrb}, 32'hF);

        // 0:500 1:120 2:300 3:120 -> best 120@1, second 120 (tie), count 4
        cost_thresh = 16'd200; cost_margin = 16'd0;
        sb.push_back({1'b0, 32'h0001_0078});
        sb.push_back({1'b1, 32'h8004_0078});
        send_beat(32'h0000_01F4, 1'b0);
        check("busy_after_beat", {31'b0, busy}, 32'd1);
        send_beat(32'h0001_0078, 1'b0);
        send_beat(32'h0002_012C, 1'b0);
        send_beat(32'h0003_0078, 1'b1);

        cost_margin = 16'd200;
        sb.push_back({1'b0, 32'h0001_0078});
        sb.push_back({1'b1, 32'h0004_0078});
        send_beat(32'h0000_01F4, 1'b0);
        send_beat(32'h0001_0078, 1'b0);
        send_beat(32'h0002_012C, 1'b0);
        send_beat(32'h0003_0078, 1'b1);

        // single beat; this summary's word0 is held off for 5 cycles
        cost_thresh = 16'd100; cost_margin = 16'd0;
        sb.push_back({1'b0, 32'h0007_0032});
        sb.push_back({1'b1, 32'h8001_FFFF});
        send_beat(32'h0007_0032, 1'b1);

        // clr mid-query: two beats, then a dropped beat in the clr cycle
        wait_idle();
        send_beat(32'h0000_0010, 1'b0);
        send_beat(32'h0001_0020, 1'b0);
        clr = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h0002_0005; s_tlast = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        clr = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        check("clr_busy", {31'b0, busy}, 32'd0);
        check("clr_mid_query_cnt", query_cnt, 32'd3);
        cost_thresh = 16'd0;
        sb.push_back({1'b0, 32'h0003_0028});
        sb.push_back({1'b1, 32'h0002_003C});
        send_beat(32'h0003_0028, 1'b0);
        send_beat(32'h0009_003C, 1'b1);

        // every cost FFFF
        cost_thresh = 16'hFFFF; cost_margin = 16'd0;
        q = {32'h0005_FFFF, 32'h0006_FFFF};
        send_query(q, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int len;
            q = {};
            len = (n == 20) ? 25 : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                int r;
                logic [15:0] c;
                r = $urandom_range(0, 9);
                if (r < 2)      c = 16'hFFFF;
                else if (r < 5) c = 16'($urandom_range(0, 7));
                else            c = 16'($urandom);
                q.push_back({16'($urandom), c});
            end
            send_query(q, 1'b1);
        end

        // clr while idle clears query_cnt
        wait_idle();
        clr = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        clr = 1'b0;
        check("clr_idle_query_cnt", query_cnt, 32'd0);
        qcnt_off = mon_qcnt;
        q = {32'h1234_0100, 32'h0042_0010};
        send_query(q, 1'b1);
        wait_idle();

        // async reset while in S_EMIT1
        mon_en = 1'b0; man_ready = 1'b0;
        @(negedge aclk);
        send_beat(32'h0007_0032, 1'b1);
        t = 0;
        while (!m_tvalid && t < 100) begin
            @(negedge aclk);
            t++;
        end
        check("emit_valid", {31'b0, m_tvalid}, 32'd1);
        man_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        man_ready = 1'b0;
        check("emit1_tlast", {31'b0, m_tlast}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("arst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        check("arst_query_cnt", query_cnt, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("arst_s_tready", {31'b0, s_tready}, 32'd1);
        check("arst_busy", {31'b0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
